// File: rtl/seg7_pkg.sv
// Shared types and constants for the multiplexed 7-segment scanner:
// scan FSM encoding, PWM wrap value and the hex-to-segment table.
package seg7_pkg;

   typedef enum logic [1:0] {
      BLANK  = 2'd0,
      SELECT = 2'd1,
      ON     = 2'd2
   } scanState_t;

   // pwm_cnt runs 0..PWM_MAX, so brightness 15 keeps segments lit continuously
   localparam logic [3:0] PWM_MAX = 4'd14;

   // Active-high segment patterns, bit6 = a .. bit0 = g, indexed by nibble
   localparam logic [6:0] SEG_TABLE [16] = '{
      7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
      7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
      7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
      7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
   };

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble to active-high abcdefg segment pattern.
module seg7_hex_decode
   import seg7_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] pattern
);

   assign pattern = SEG_TABLE[nibble];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scanner: tick-enabled BLANK/SELECT/ON scan over the
// enabled digits, shadow-latched digit data, PWM dimming and output polarity.
module seg7_scan_ctrl
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS     = 8,
   parameter int CLK_DIV        = 330,
   parameter int BLANK_TICKS    = 3,
   parameter int ON_TICKS       = 50,
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   parameter bit AN_ACTIVE_LOW  = 1'b1
)(
   input  logic                    clk,
   input  logic                    rstn,
   input  logic [4*NUM_DIGITS-1:0] hex_data,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic [NUM_DIGITS-1:0]   digit_en,
   input  logic [3:0]              brightness,
   output logic [6:0]              seg,
   output logic                    dp,
   output logic [NUM_DIGITS-1:0]   an,
   output logic [((NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1)-1:0] scan_idx,
   output logic                    frame_done
);

   localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int DIV_W  = $clog2(CLK_DIV);
   localparam int PH_MAX = (BLANK_TICKS > ON_TICKS) ? BLANK_TICKS : ON_TICKS;
   localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

   localparam logic [NUM_DIGITS-1:0] AN_IDLE  = {NUM_DIGITS{AN_ACTIVE_LOW}};
   localparam logic [6:0]            SEG_IDLE = {7{SEG_ACTIVE_LOW}};

   logic [DIV_W-1:0]       divCnt;
   logic                   tick;
   scanState_t             state, stateNext;
   logic [PH_W-1:0]        phaseCnt, phaseNext;
   logic [IDX_W-1:0]       idx, idxNext, nextEnIdx;
   logic [2**IDX_W-1:0]    enPad;
   logic                   anyEn, anyAbove;
   logic                   latchShadow, frameEnd;
   logic [3:0]             selHex, shadowHex, pwmCnt;
   logic                   selDp, shadowDp;
   logic [6:0]             segPattern;
   logic [NUM_DIGITS-1:0]  anSel;
   logic                   lit, segOn;

   // Scan tick: one clk in every CLK_DIV
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         divCnt <= '0;
      end else if (tick) begin
         divCnt <= '0;
      end else begin
         divCnt <= divCnt + DIV_W'(1);
      end
   end

   assign tick = (divCnt == DIV_W'(CLK_DIV - 1));

   // Free-running PWM phase, independent of the scan tick
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pwmCnt <= '0;
      end else if (pwmCnt == PWM_MAX) begin
         pwmCnt <= '0;
      end else begin
         pwmCnt <= pwmCnt + 4'd1;
      end
   end

   // Next enabled digit after idx, searched cyclically; the padding bits stay
   // zero so a non-power-of-two digit count never selects a phantom digit.
   assign enPad = (2**IDX_W)'(digit_en);
   assign anyEn = |digit_en;

   always_comb begin
      nextEnIdx = idx;
      anyAbove  = 1'b0;
      selHex    = '0;
      selDp     = 1'b0;
      for (int j = NUM_DIGITS; j >= 1; j--) begin
         if (enPad[IDX_W'((int'(idx) + j) % NUM_DIGITS)]) begin
            nextEnIdx = IDX_W'((int'(idx) + j) % NUM_DIGITS);
         end
      end
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (i > int'(idx) && digit_en[i]) begin
            anyAbove = 1'b1;
         end
         if (nextEnIdx == IDX_W'(i)) begin
            selHex = hex_data[4*i +: 4];
            selDp  = dp_in[i];
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state    <= BLANK;
         phaseCnt <= '0;
         idx      <= IDX_W'(NUM_DIGITS - 1);
      end else begin
         state    <= stateNext;
         phaseCnt <= phaseNext;
         idx      <= idxNext;
      end
   end

   always_comb begin
      stateNext   = state;
      phaseNext   = phaseCnt;
      idxNext     = idx;
      latchShadow = 1'b0;
      frameEnd    = 1'b0;
      if (tick) begin
         unique case (state)
            BLANK: begin
               // With nothing enabled the blanking phase simply parks
               if (anyEn) begin
                  if (phaseCnt == PH_W'(BLANK_TICKS - 1)) begin
                     stateNext = SELECT;
                     phaseNext = '0;
                  end else begin
                     phaseNext = phaseCnt + PH_W'(1);
                  end
               end
            end
            SELECT: begin
               if (anyEn) begin
                  idxNext     = nextEnIdx;
                  latchShadow = 1'b1;
                  stateNext   = ON;
               end else begin
                  stateNext = BLANK;
               end
            end
            ON: begin
               if (phaseCnt == PH_W'(ON_TICKS - 1)) begin
                  stateNext = BLANK;
                  phaseNext = '0;
                  frameEnd  = !anyAbove;
               end else begin
                  phaseNext = phaseCnt + PH_W'(1);
               end
            end
            default: begin
               stateNext = BLANK;
               phaseNext = '0;
            end
         endcase
      end
   end

   // Shadow copy keeps the lit digit stable while software rewrites inputs
   always_ff @(posedge clk) begin
      if (latchShadow) begin
         shadowHex <= selHex;
         shadowDp  <= selDp;
      end
   end

   seg7_hex_decode uDecode (
      .nibble  (shadowHex),
      .pattern (segPattern)
   );

   assign anSel = NUM_DIGITS'(1) << idx;
   assign lit   = (state == ON);
   assign segOn = lit && (pwmCnt < brightness);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         an         <= AN_IDLE;
         seg        <= SEG_IDLE;
         dp         <= SEG_ACTIVE_LOW;
         scan_idx   <= '0;
         frame_done <= 1'b0;
      end else begin
         an         <= (lit ? anSel : '0) ^ AN_IDLE;
         seg        <= (segOn ? segPattern : 7'b0) ^ SEG_IDLE;
         dp         <= (segOn & shadowDp) ^ SEG_ACTIVE_LOW;
         frame_done <= frameEnd;
         if (lit) begin
            scan_idx <= idx;
         end
      end
   end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl: an 8-digit instance with a short scan
// timing plus a free-running single-digit instance.
module tb_seg7_scan_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rstn  = 1'b1;
   logic        rstn1 = 1'b1;
   logic [31:0] hexData;
   logic [7:0]  dpIn, digitEn;
   logic [3:0]  brightness;
   logic [6:0]  seg;
   logic        dp;
   logic [7:0]  an;
   logic [2:0]  scanIdx;
   logic        frameDone;

   logic [3:0]  hexData1;
   logic [0:0]  dpIn1, digitEn1, an1, scanIdx1;
   logic [6:0]  seg1;
   logic        dp1, frameDone1;

   int checks   = 0;
   int failures = 0;

   // Active-low expected segment codes
   localparam logic [6:0] S_0 = 7'b0000001;
   localparam logic [6:0] S_3 = 7'b0000110;
   localparam logic [6:0] S_7 = 7'b0001111;
   localparam logic [6:0] S_8 = 7'b0000000;
   localparam logic [6:0] S_A = 7'b0001000;
   localparam logic [6:0] S_C = 7'b0110001;
   localparam logic [6:0] S_F = 7'b0111000;
   localparam logic [6:0] S_OFF = 7'b1111111;

   seg7_scan_ctrl #(
      .NUM_DIGITS(8), .CLK_DIV(4), .BLANK_TICKS(2), .ON_TICKS(5),
      .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
   ) dut (
      .clk(clk), .rstn(rstn), .hex_data(hexData), .dp_in(dpIn),
      .digit_en(digitEn), .brightness(brightness), .seg(seg), .dp(dp),
      .an(an), .scan_idx(scanIdx), .frame_done(frameDone)
   );

   seg7_scan_ctrl #(
      .NUM_DIGITS(1), .CLK_DIV(4), .BLANK_TICKS(2), .ON_TICKS(5),
      .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
   ) dut1 (
      .clk(clk), .rstn(rstn1), .hex_data(hexData1), .dp_in(dpIn1),
      .digit_en(digitEn1), .brightness(4'd15), .seg(seg1), .dp(dp1),
      .an(an1), .scan_idx(scanIdx1), .frame_done(frameDone1)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic waitAn(input logic [7:0] v, input int budget, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (an !== v && n < budget);
      check("wait_an", an, v);
   endtask

   task automatic waitFd(input int budget, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (frameDone !== 1'b1 && n < budget);
      check("wait_frame_done", frameDone, 1'b1);
   endtask

   task automatic doReset();
      rstn = 1'b0;
      repeat (3) @(negedge clk);
      rstn = 1'b1;
   endtask

   initial begin
      int n, cLit, cDark, cDp, cAn, cBad, cFd;

      hexData = 32'h12345678; dpIn = '0; digitEn = 8'hFF; brightness = 4'd15;
      hexData1 = 4'h3; dpIn1 = '0; digitEn1 = 1'b1;
      #1 rstn = 1'b0; rstn1 = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_an", an, 8'hFF);
      check("rst_seg", seg, S_OFF);
      check("rst_dp", dp, 1'b1);
      check("rst_scan_idx", scanIdx, 3'd0);
      check("rst_frame_done", frameDone, 1'b0);
      check("rst_an1", an1, 1'b1);
      rstn = 1'b1; rstn1 = 1'b1;

      // Full scan across all eight digits
      waitAn(8'hFE, 100, n);
      check("full_d0_seg", seg, S_8);
      check("full_d0_dp", dp, 1'b1);
      check("full_d0_idx", scanIdx, 3'd0);
      waitAn(8'hFD, 100, n);
      check("full_d1_delay", n, 32);
      check("full_d1_seg", seg, S_7);
      check("full_d1_idx", scanIdx, 3'd1);
      waitFd(600, n);
      @(negedge clk);
      check("full_fd_width", frameDone, 1'b0);
      waitFd(600, n);
      check("full_fd_period", n + 1, 256);

      // Skip mask: only digits 0 and 4
      digitEn = 8'b0001_0001; hexData = 32'h000A000C;
      doReset();
      waitAn(8'hFE, 100, n);
      check("skip_d0_seg", seg, S_C);
      waitAn(8'hEF, 100, n);
      check("skip_d4_delay", n, 32);
      check("skip_d4_seg", seg, S_A);
      check("skip_d4_idx", scanIdx, 3'd4);
      waitAn(8'hFE, 100, n);
      check("skip_back_delay", n, 32);
      waitFd(200, n);
      waitFd(200, n);
      check("skip_fd_period", n, 64);

      // Shadow latch: data change mid-ON only shows at the next ON
      digitEn = 8'h01; hexData = 32'h0;
      doReset();
      waitAn(8'hFE, 100, n);
      repeat (5) @(negedge clk);
      hexData[3:0] = 4'hF;
      repeat (3) @(negedge clk);
      check("shadow_hold_seg", seg, S_0);
      check("shadow_hold_an", an, 8'hFE);
      waitAn(8'hFF, 40, n);
      waitAn(8'hFE, 40, n);
      check("shadow_new_seg", seg, S_F);

      // Disabling a lit digit lets it finish, then it is skipped
      digitEn = 8'h03; hexData = 32'h0;
      doReset();
      waitAn(8'hFE, 100, n);
      cAn = 1;
      repeat (5) begin
         @(negedge clk);
         if (an === 8'hFE) cAn++;
      end
      digitEn = 8'h02;
      while (an === 8'hFE && cAn < 100) begin
         @(negedge clk);
         if (an === 8'hFE) cAn++;
      end
      check("mask_on_len", cAn, 20);
      cBad = 0; cLit = 0;
      repeat (200) begin
         @(negedge clk);
         if (an === 8'hFE) cBad++;
         if (an === 8'hFD) cLit++;
      end
      check("mask_d0_gone", cBad, 0);
      check("mask_d1_lit", cLit > 0, 1'b1);

      // PWM at brightness 5 with decimal point
      digitEn = 8'h01; hexData = 32'h0; dpIn = 8'h01; brightness = 4'd5;
      doReset();
      waitAn(8'hFE, 100, n);
      cLit = 0; cDark = 0; cDp = 0; cAn = 0;
      for (int i = 0; i < 15; i++) begin
         if (i > 0) @(negedge clk);
         if (seg === S_0) cLit++;
         if (seg === S_OFF) cDark++;
         if (dp === 1'b0) cDp++;
         if (an === 8'hFE) cAn++;
      end
      check("pwm5_seg_on", cLit, 5);
      check("pwm5_seg_off", cDark, 10);
      check("pwm5_dp_on", cDp, 5);
      check("pwm5_an_on", cAn, 15);

      brightness = 4'd0;
      doReset();
      waitAn(8'hFE, 100, n);
      cDark = 0; cDp = 0; cAn = 0;
      for (int i = 0; i < 15; i++) begin
         if (i > 0) @(negedge clk);
         if (seg === S_OFF) cDark++;
         if (dp === 1'b1) cDp++;
         if (an === 8'hFE) cAn++;
      end
      check("pwm0_seg_off", cDark, 15);
      check("pwm0_dp_off", cDp, 15);
      check("pwm0_an_on", cAn, 15);

      // No digit enabled: stays dark, no frame strobe
      digitEn = 8'h00; brightness = 4'd15; dpIn = 8'h00;
      doReset();
      cBad = 0; cFd = 0;
      repeat (1000) begin
         @(negedge clk);
         if (an !== 8'hFF || seg !== S_OFF || dp !== 1'b1) cBad++;
         if (frameDone !== 1'b0) cFd++;
      end
      check("none_outputs_idle", cBad, 0);
      check("none_frame_done", cFd, 0);

      // Asynchronous reset while a digit is lit
      digitEn = 8'hFF; hexData = 32'h12345678;
      doReset();
      waitAn(8'hFE, 100, n);
      repeat (3) @(negedge clk);
      rstn = 1'b0;
      #1;
      check("arst_an", an, 8'hFF);
      check("arst_seg", seg, S_OFF);
      check("arst_dp", dp, 1'b1);
      @(negedge clk);
      rstn = 1'b1;

      // Single-digit build cycles with a 32-clk period
      n = 0;
      while (an1 !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      n = 0;
      while (an1 !== 1'b0 && n < 100) begin @(negedge clk); n++; end
      check("n1_lit", an1, 1'b0);
      check("n1_seg", seg1, S_3);
      cLit = 0;
      while (an1 === 1'b0 && cLit < 100) begin @(negedge clk); cLit++; end
      check("n1_on_len", cLit, 20);
      n = cLit;
      while (an1 === 1'b1 && n < 200) begin @(negedge clk); n++; end
      check("n1_period", n, 32);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
